// File: rtl/hv_owt_arb_pkg.sv
// Shared types and width helpers for the HV one-wire transmit arbiter.
package hv_owt_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_GAP
    } owt_arb_st_e;

    // Holds GAP_CYC-1 for the largest allowed gap (255 cycles).
    localparam int GAP_CNT_W = 8;

    function automatic int tmo_cnt_w(input int start_tmo, input int frame_tmo);
        return $clog2(((start_tmo > frame_tmo) ? start_tmo : frame_tmo) + 1);
    endfunction

    function automatic int rr_ptr_w(input int num_req);
        return (num_req > 2) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/hv_owt_rr_sel.sv
// Combinational round-robin picker over the non-urgent requesters 1..NUM_REQ-1.
module hv_owt_rr_sel #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:1] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   idx,
    output logic               vld
);

    // Search starts just after the last granted index and wraps from NUM_REQ-1 back to 1.
    always_comb begin
        int cand;
        cand = 0;
        gnt  = '0;
        idx  = '0;
        vld  = 1'b0;
        for (int off = 1; off < NUM_REQ; off++) begin
            cand = int'(ptr) + off;
            if (cand > NUM_REQ - 1) begin
                cand = cand - (NUM_REQ - 1);
            end
            if (!vld && req[PTR_W'(cand)]) begin
                vld                = 1'b1;
                gnt[PTR_W'(cand)]  = 1'b1;
                idx                = PTR_W'(cand);
            end
        end
    end

endmodule

// File: rtl/hv_owt_tx_arb.sv
// HV one-wire transmit arbiter: grants one client frame at a time, launches it,
// tracks completion via the controller busy flag and enforces gap and timeouts.
module hv_owt_tx_arb
    import hv_owt_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int AW        = 7,
    parameter int DW        = 16,
    parameter int GAP_CYC   = 24,
    parameter int START_TMO = 8,
    parameter int FRAME_TMO = 4095
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_arb_en,
    input  logic [NUM_REQ-1:0]    i_req_vld,
    input  logic [NUM_REQ-1:0]    i_req_wr,
    input  logic [NUM_REQ*AW-1:0] i_req_addr,
    input  logic [NUM_REQ*DW-1:0] i_req_data,
    output logic [NUM_REQ-1:0]    o_req_ack,
    output logic [NUM_REQ-1:0]    o_req_done,
    output logic                  o_req_err,
    output logic                  o_owt_tx_wr_cmd_vld,
    output logic                  o_owt_tx_rd_cmd_vld,
    output logic [AW-1:0]         o_owt_tx_addr,
    output logic [DW-1:0]         o_owt_tx_data,
    input  logic                  i_owt_tx_busy,
    output logic                  o_tmo_err,
    output logic                  o_arb_busy
);

    localparam int CNT_W = tmo_cnt_w(START_TMO, FRAME_TMO);
    localparam int PTR_W = rr_ptr_w(NUM_REQ);

    owt_arb_st_e            state_q, state_d;
    logic [CNT_W-1:0]       tmo_cnt_q;
    logic [GAP_CNT_W-1:0]   gap_cnt_q;
    logic [PTR_W-1:0]       rr_ptr_q, owner_q, rr_idx, win_idx;
    logic [NUM_REQ-1:0]     rr_gnt, win_gnt;
    logic                   rr_vld, grant, done_fire, done_err;
    logic                   lat_wr_q, tmo_err_q;
    logic [AW-1:0]          addr_q;
    logic [DW-1:0]          data_q;

    hv_owt_rr_sel #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_sel (
        .req (i_req_vld[NUM_REQ-1:1]),
        .ptr (rr_ptr_q),
        .gnt (rr_gnt),
        .idx (rr_idx),
        .vld (rr_vld)
    );

    // Requester 0 overrides the round-robin choice without disturbing its pointer.
    always_comb begin
        win_gnt = rr_gnt;
        win_idx = rr_idx;
        if (i_req_vld[0]) begin
            win_gnt = NUM_REQ'(1);
            win_idx = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant     = 1'b0;
        done_fire = 1'b0;
        done_err  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_arb_en && (i_req_vld[0] || rr_vld)) begin
                    grant   = 1'b1;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (i_owt_tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmo_cnt_q == CNT_W'(START_TMO)) begin
                    done_fire = 1'b1;
                    done_err  = 1'b1;
                    state_d   = ST_GAP;
                end
            end
            ST_WAIT_DONE: begin
                if (!i_owt_tx_busy) begin
                    done_fire = 1'b1;
                    state_d   = ST_GAP;
                end else if (tmo_cnt_q == CNT_W'(FRAME_TMO)) begin
                    done_fire = 1'b1;
                    done_err  = 1'b1;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // An aborted frame must not report completion, and nothing is acked that won't latch.
        if (i_rst) begin
            grant     = 1'b0;
            done_fire = 1'b0;
            done_err  = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            tmo_cnt_q <= '0;
            gap_cnt_q <= '0;
            rr_ptr_q  <= PTR_W'(NUM_REQ - 1);
            owner_q   <= '0;
            lat_wr_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                tmo_cnt_q <= '0;
            end else if (tmo_cnt_q != '1) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
            if (done_fire) begin
                gap_cnt_q <= GAP_CNT_W'(GAP_CYC - 1);
            end else if (state_q == ST_GAP && gap_cnt_q != '0) begin
                gap_cnt_q <= gap_cnt_q - 1'b1;
            end
            if (grant) begin
                owner_q  <= win_idx;
                lat_wr_q <= i_req_wr[win_idx];
                addr_q   <= i_req_addr[win_idx*AW +: AW];
                data_q   <= i_req_data[win_idx*DW +: DW];
                if (!i_req_vld[0]) begin
                    rr_ptr_q <= rr_idx;
                end
            end
            if (done_fire && done_err) begin
                tmo_err_q <= 1'b1;
            end
        end
    end

    assign o_req_ack           = grant ? win_gnt : '0;
    assign o_req_done          = done_fire ? (NUM_REQ'(1) << owner_q) : '0;
    assign o_req_err           = done_err;
    assign o_owt_tx_wr_cmd_vld = (state_q == ST_LAUNCH) && lat_wr_q;
    assign o_owt_tx_rd_cmd_vld = (state_q == ST_LAUNCH) && !lat_wr_q;
    assign o_owt_tx_addr       = addr_q;
    assign o_owt_tx_data       = data_q;
    assign o_tmo_err           = tmo_err_q;
    assign o_arb_busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hv_owt_tx_arb.sv
// Directed bench for hv_owt_tx_arb: grant order, launch pulses, gap spacing,
// timeouts, enable gating and mid-frame reset.
module tb_hv_owt_tx_arb;

    localparam int NUM_REQ = 4;
    localparam int AW      = 7;
    localparam int DW      = 16;

    logic                  i_clk = 1'b0;
    logic                  i_rst;
    logic                  i_arb_en;
    logic [NUM_REQ-1:0]    i_req_vld;
    logic [NUM_REQ-1:0]    i_req_wr;
    logic [NUM_REQ*AW-1:0] i_req_addr;
    logic [NUM_REQ*DW-1:0] i_req_data;
    logic [NUM_REQ-1:0]    o_req_ack;
    logic [NUM_REQ-1:0]    o_req_done;
    logic                  o_req_err;
    logic                  o_owt_tx_wr_cmd_vld;
    logic                  o_owt_tx_rd_cmd_vld;
    logic [AW-1:0]         o_owt_tx_addr;
    logic [DW-1:0]         o_owt_tx_data;
    logic                  i_owt_tx_busy;
    logic                  o_tmo_err;
    logic                  o_arb_busy;

    int total_cnt = 0;
    int bad_cnt   = 0;

    hv_owt_tx_arb dut (
        .i_clk               (i_clk),
        .i_rst               (i_rst),
        .i_arb_en            (i_arb_en),
        .i_req_vld           (i_req_vld),
        .i_req_wr            (i_req_wr),
        .i_req_addr          (i_req_addr),
        .i_req_data          (i_req_data),
        .o_req_ack           (o_req_ack),
        .o_req_done          (o_req_done),
        .o_req_err           (o_req_err),
        .o_owt_tx_wr_cmd_vld (o_owt_tx_wr_cmd_vld),
        .o_owt_tx_rd_cmd_vld (o_owt_tx_rd_cmd_vld),
        .o_owt_tx_addr       (o_owt_tx_addr),
        .o_owt_tx_data       (o_owt_tx_data),
        .i_owt_tx_busy       (i_owt_tx_busy),
        .o_tmo_err           (o_tmo_err),
        .o_arb_busy          (o_arb_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total_cnt++;
        if (got !== want) begin
            bad_cnt++;
            $display("[TB] FAIL %s got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic applyStimulus(input int idx, input logic wr, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] data);
        i_req_wr[idx]             = wr;
        i_req_addr[idx*AW +: AW]  = addr;
        i_req_data[idx*DW +: DW]  = data;
        i_req_vld[idx]            = 1'b1;
    endtask

    task automatic doReset();
        i_rst         = 1'b1;
        i_req_vld     = '0;
        i_owt_tx_busy = 1'b0;
        i_arb_en      = 1'b1;
        repeat (2) tick();
        i_rst = 1'b0;
    endtask

    task automatic waitGrant(input int maxc, output int n, output logic [NUM_REQ-1:0] a);
        n = 0;
        #1 a = o_req_ack;
        while (a == '0 && n < maxc) begin
            tick();
            #1 a = o_req_ack;
            n++;
        end
    endtask

    task automatic waitDone(input int maxc, output int n, output logic [NUM_REQ-1:0] dn,
                            output logic er);
        n = 0;
        #1 dn = o_req_done;
        er = o_req_err;
        while (dn == '0 && n < maxc) begin
            tick();
            #1 dn = o_req_done;
            er = o_req_err;
            n++;
        end
    endtask

    // Called in the LAUNCH cycle; busy is held high for 'hold' cycles from WAIT_BUSY on.
    task automatic serveFrame(input int hold, output logic [NUM_REQ-1:0] dn, output logic er);
        tick();
        i_owt_tx_busy = 1'b1;
        repeat (hold) tick();
        i_owt_tx_busy = 1'b0;
        #1 dn = o_req_done;
        er = o_req_err;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int                 n;
        logic [NUM_REQ-1:0] a, dn, seen;
        logic               er;
        logic [NUM_REQ-1:0] rr_exp [4];
        rr_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0010};
        i_req_wr   = '0;
        i_req_addr = '0;
        i_req_data = '0;

        doReset();
        #1;
        checkOutput("rst_busy", 32'(o_arb_busy), 0);
        checkOutput("rst_tmo", 32'(o_tmo_err), 0);
        checkOutput("rst_addr", 32'(o_owt_tx_addr), 0);
        checkOutput("rst_data", 32'(o_owt_tx_data), 0);
        checkOutput("rst_pulses", 32'({o_req_ack, o_req_done, o_req_err,
                    o_owt_tx_wr_cmd_vld, o_owt_tx_rd_cmd_vld}), 0);

        // Single read from requester 2 with a 300-cycle frame.
        applyStimulus(2, 1'b0, 7'h15, 16'hBEEF);
        #1 checkOutput("rd_ack", 32'(o_req_ack), 32'h4);
        tick();
        i_req_vld[2] = 1'b0;
        #1;
        checkOutput("rd_cmd", 32'({o_owt_tx_rd_cmd_vld, o_owt_tx_wr_cmd_vld}), 32'h2);
        checkOutput("rd_addr", 32'(o_owt_tx_addr), 32'h15);
        checkOutput("rd_data", 32'(o_owt_tx_data), 32'hBEEF);
        serveFrame(300, dn, er);
        checkOutput("rd_done", 32'(dn), 32'h4);
        checkOutput("rd_err", 32'(er), 0);
        tick();
        applyStimulus(1, 1'b1, 7'h2A, 16'h1234);
        #1 checkOutput("gap_addr_hold", 32'(o_owt_tx_addr), 32'h15);
        waitGrant(60, n, a);
        checkOutput("gap_spacing", 32'(n), 24);
        checkOutput("gap_next_ack", 32'(a), 32'h2);
        tick();
        i_req_vld[1] = 1'b0;
        #1 checkOutput("wr_cmd", 32'({o_owt_tx_rd_cmd_vld, o_owt_tx_wr_cmd_vld}), 32'h1);

        // Round-robin among 1..3, then urgent requester 0 cuts in.
        doReset();
        applyStimulus(1, 1'b0, 7'h01, 16'h0101);
        applyStimulus(2, 1'b0, 7'h02, 16'h0202);
        applyStimulus(3, 1'b0, 7'h03, 16'h0303);
        for (int k = 0; k < 4; k++) begin
            waitGrant(60, n, a);
            checkOutput($sformatf("rr_grant_%0d", k), 32'(a), 32'(rr_exp[k]));
            tick();
            if (k == 3) applyStimulus(0, 1'b1, 7'h7F, 16'hFFFF);
            serveFrame(3, dn, er);
            checkOutput($sformatf("rr_done_%0d", k), 32'(dn), 32'(rr_exp[k]));
        end
        waitGrant(60, n, a);
        checkOutput("urgent_grant", 32'(a), 32'h1);
        tick();
        i_req_vld[0] = 1'b0;
        serveFrame(3, dn, er);
        checkOutput("urgent_done", 32'(dn), 32'h1);
        waitGrant(60, n, a);
        checkOutput("rr_resume", 32'(a), 32'h4);
        tick();
        serveFrame(3, dn, er);
        checkOutput("rr_resume_done", 32'(dn), 32'h4);
        i_req_vld = '0;

        // Busy never rises: start timeout.
        applyStimulus(3, 1'b0, 7'h05, 16'h0000);
        waitGrant(60, n, a);
        checkOutput("st_ack", 32'(a), 32'h8);
        tick();
        i_req_vld[3] = 1'b0;
        tick();
        #1 checkOutput("st_tmo_before", 32'(o_tmo_err), 0);
        waitDone(40, n, dn, er);
        checkOutput("st_tmo_cycles", 32'(n), 8);
        checkOutput("st_tmo_done", 32'(dn), 32'h8);
        checkOutput("st_tmo_err", 32'(er), 1);
        tick();
        #1 checkOutput("st_tmo_sticky", 32'(o_tmo_err), 1);

        // Busy stuck high: frame timeout; busy already high in LAUNCH is harmless.
        applyStimulus(1, 1'b1, 7'h11, 16'h2222);
        waitGrant(60, n, a);
        checkOutput("ft_ack", 32'(a), 32'h2);
        tick();
        i_req_vld[1]  = 1'b0;
        i_owt_tx_busy = 1'b1;
        tick();
        tick();
        waitDone(4200, n, dn, er);
        checkOutput("ft_tmo_cycles", 32'(n), 4095);
        checkOutput("ft_tmo_done", 32'(dn), 32'h2);
        checkOutput("ft_tmo_err", 32'(er), 1);
        tick();
        i_owt_tx_busy = 1'b0;
        #1 checkOutput("ft_gap_busy", 32'(o_arb_busy), 1);
        n = 0;
        while (o_arb_busy && n < 60) begin
            tick();
            #1 n++;
        end
        checkOutput("ft_gap_len", 32'(n), 24);
        checkOutput("ft_tmo_sticky", 32'(o_tmo_err), 1);

        // Enable gating.
        doReset();
        #1 checkOutput("rst_clears_tmo", 32'(o_tmo_err), 0);
        i_arb_en = 1'b0;
        applyStimulus(1, 1'b0, 7'h21, 16'h0021);
        seen = '0;
        for (int c = 0; c < 5; c++) begin
            #1 seen |= o_req_ack;
            tick();
        end
        checkOutput("en_off_no_ack", 32'({seen, o_arb_busy}), 0);
        i_arb_en = 1'b1;
        #1 checkOutput("en_on_ack", 32'(o_req_ack), 32'h2);
        tick();
        i_req_vld[1] = 1'b0;
        i_arb_en     = 1'b0;
        applyStimulus(2, 1'b0, 7'h22, 16'h0022);
        serveFrame(5, dn, er);
        checkOutput("en_off_frame_done", 32'(dn), 32'h2);
        seen = '0;
        for (int c = 0; c < 40; c++) begin
            tick();
            #1 seen |= o_req_ack;
        end
        checkOutput("en_off_no_regrant", 32'({seen, o_arb_busy}), 0);
        i_req_vld = '0;
        i_arb_en  = 1'b1;

        // Reset during WAIT_DONE.
        applyStimulus(2, 1'b1, 7'h33, 16'hA5A5);
        waitGrant(10, n, a);
        checkOutput("mr_ack", 32'(a), 32'h4);
        tick();
        i_req_vld[2] = 1'b0;
        tick();
        i_owt_tx_busy = 1'b1;
        repeat (4) tick();
        i_rst         = 1'b1;
        i_owt_tx_busy = 1'b0;
        #1 checkOutput("mr_no_done", 32'(o_req_done), 0);
        tick();
        i_rst = 1'b0;
        #1;
        checkOutput("mr_busy", 32'(o_arb_busy), 0);
        checkOutput("mr_addr", 32'(o_owt_tx_addr), 0);
        checkOutput("mr_data", 32'(o_owt_tx_data), 0);
        checkOutput("mr_pulses", 32'({o_req_done, o_req_err, o_owt_tx_wr_cmd_vld,
                    o_owt_tx_rd_cmd_vld}), 0);
        applyStimulus(3, 1'b0, 7'h4C, 16'h004C);
        #1 checkOutput("mr_next_ack", 32'(o_req_ack), 32'h8);
        tick();
        i_req_vld[3] = 1'b0;
        #1;
        checkOutput("mr_next_cmd", 32'({o_owt_tx_rd_cmd_vld, o_owt_tx_wr_cmd_vld}), 32'h2);
        checkOutput("mr_next_addr", 32'(o_owt_tx_addr), 32'h4C);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
